decode_issue_ctrl: RTL
======================

Name: decode_issue_ctrl

Overview:
- Sequences the decode stage between fetch and execute.
- Holds one instruction in a stage register and drives it into the combinational decoder.
- Uses the decoded register fields and type flags to check a load-use scoreboard, then issues to execute over a valid/ready handshake.
- Handles pipeline flush and keeps a saturating stall-cycle counter.

Parameters:
- XLEN, 64, width of PC and immediate datapath.
- STALL_CNT_W, 32, width of the stall-cycle counter.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- fetch_valid_i  in  1  fetch offers an instruction.
- fetch_instr_i  in  32  offered instruction word.
- fetch_pc_i  in  XLEN  PC of the offered instruction.
- fetch_ready_o  out  1  stage accepts the offered instruction this cycle.
- dec_instr_o  out  32  held instruction, driven to the decoder.
- dec_rs1_i, dec_rs2_i, dec_rd_i  in  5 each  decoder register fields.
- dec_op_i  in  7  decoder opcode.
- dec_r_type_i, dec_i_type_i, dec_s_type_i, dec_b_type_i  in  1 each  decoder type flags.
- ex_valid_o  out  1  issue offer to execute.
- ex_ready_i  in  1  execute accepts.
- ex_instr_o  out  32  issued instruction; equals held instruction.
- ex_pc_o  out  XLEN  issued PC.
- wb_valid_i  in  1  a load result writes back this cycle.
- wb_rd_i  in  5  destination of that write-back.
- flush_i  in  1  redirect; kill held and offered instructions.
- stall_cnt_o  out  STALL_CNT_W  cycles the held instruction was blocked by a hazard.

Behaviour:
- Reset is asynchronous, active-high, and applies immediately:
  - state = EMPTY.
  - Held instruction = 32'h0000_0013 (NOP); held PC = 0.
  - Scoreboard busy[31:0] = 0; stall_cnt_o = 0.
  - ex_valid_o = 0; fetch_ready_o = 0 while rst_i is high.
- State machine, two states: EMPTY and HOLD.
- Source usage:
  - uses_rs1 = r | i | s | b.
  - uses_rs2 = r | s | b.
  - is_load = (dec_op_i == 7'b0000011).
- hazard = (uses_rs1 & busy[dec_rs1_i]) | (uses_rs2 & busy[dec_rs2_i]). busy[0] is hardwired to 0.
- ex_valid_o = (state == HOLD) & ~hazard & ~flush_i.
- issue = ex_valid_o & ex_ready_i.
- fetch_ready_o = ~rst_i & ~flush_i & ((state == EMPTY) | issue). This is a combinational path from ex_ready_i, accepted so that back-to-back throughput is one instruction per cycle.
- accept = fetch_valid_i & fetch_ready_o. On accept, load fetch_instr_i and fetch_pc_i into the stage register.
- Transitions:
  - EMPTY -> HOLD on accept.
  - HOLD -> HOLD on issue & accept.
  - HOLD -> EMPTY on issue & ~accept.
  - Otherwise hold state.
- Flush has priority over everything else:
  - Next state = EMPTY; nothing issues or is accepted that cycle.
  - Held instruction is reset to NOP.
  - Scoreboard is NOT cleared, because loads already issued still write back.
- Latency: an instruction accepted in cycle N is offered on ex_valid_o in cycle N+1 if no hazard exists.
- Scoreboard update, per cycle:
  - Set busy[dec_rd_i] on issue & is_load & (dec_rd_i != 0).
  - Clear busy[wb_rd_i] on wb_valid_i.
  - If set and clear hit the same index in the same cycle, set wins.
- Hazard evaluation uses registered busy, so a write-back clears the hazard one cycle later (unless the bypass below is compiled in).
- stall_cnt_o increments by 1 each cycle with state == HOLD & hazard & ~flush_i. It saturates at all-ones and never wraps.
- ex_instr_o and ex_pc_o are driven from the stage register. They are stable while ex_valid_o is high and ex_ready_i is low.
- Once ex_valid_o rises, it stays high until issue or flush. This holds because busy only sets on issue of this stage's own instruction.

Optional Feature:
- Macro: DECODE_ISSUE_WB_BYPASS_EN.
- Defined: hazard is computed from busy & ~(wb_valid_i ? (1 << wb_rd_i) : 0). A write-back releases a dependent instruction in the same cycle, saving one stall cycle per load-use.
- Undefined: hazard uses registered busy only, as specified above.

Test Plan:
- Reset mid-operation: assert rst_i while in HOLD with busy[5]=1 -> ex_valid_o=0, fetch_ready_o=0, busy=0, stall_cnt_o=0 immediately, without waiting for a clock edge.
- Streaming with ex_ready_i=1: offer ADDI x1,x0,1 / ADDI x2,x0,2 / ADDI x3,x0,3 on consecutive cycles -> one issue per cycle, ex_pc_o = 0x0, 0x4, 0x8, stall_cnt_o=0.
- Load-use: issue LD x5; next offer ADD x6,x5,x5 -> ex_valid_o=0 until wb_valid_i=1, wb_rd_i=5. Then issue one cycle later without the bypass, or the same cycle with DECODE_ISSUE_WB_BYPASS_EN. With wb arriving 3 cycles after the ADD enters HOLD, stall_cnt_o=4 without the bypass and 3 with it.
- Backpressure: ex_ready_i=0 for 5 cycles with SW held -> ex_valid_o stays 1, ex_instr_o stable, fetch_ready_o=0, stall_cnt_o unchanged.
- Flush: flush_i=1 while HOLD with LD x7 and fetch_valid_i=1 -> no issue, no accept, next state EMPTY, busy[7] still 0. A load issued earlier keeps its busy bit.
- Set/clear collision: issue LD x9 while wb_valid_i=1, wb_rd_i=9 -> busy[9]=1 afterwards. Also LD x0 -> busy unchanged.

Source files
------------

// File: rtl/decode_issue_ctrl.sv
// Decode-stage controller: one-entry stage register, load-use scoreboard and valid/ready issue to execute.
// Optional macro DECODE_ISSUE_WB_BYPASS_EN lets a same-cycle write-back release a dependent instruction.
module decode_issue_ctrl #(
    parameter int XLEN        = 64,
    parameter int STALL_CNT_W = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   fetch_valid_i,
    input  logic [31:0]            fetch_instr_i,
    input  logic [XLEN-1:0]        fetch_pc_i,
    output logic                   fetch_ready_o,
    output logic [31:0]            dec_instr_o,
    input  logic [4:0]             dec_rs1_i,
    input  logic [4:0]             dec_rs2_i,
    input  logic [4:0]             dec_rd_i,
    input  logic [6:0]             dec_op_i,
    input  logic                   dec_r_type_i,
    input  logic                   dec_i_type_i,
    input  logic                   dec_s_type_i,
    input  logic                   dec_b_type_i,
    output logic                   ex_valid_o,
    input  logic                   ex_ready_i,
    output logic [31:0]            ex_instr_o,
    output logic [XLEN-1:0]        ex_pc_o,
    input  logic                   wb_valid_i,
    input  logic [4:0]             wb_rd_i,
    input  logic                   flush_i,
    output logic [STALL_CNT_W-1:0] stall_cnt_o
);

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [6:0]  OP_LOAD   = 7'b0000011;

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [31:0]            instr_r;
    logic [XLEN-1:0]        pc_r;
    logic [31:0]            busy_r;
    logic [31:0]            busy_nxt_s;
    logic [31:0]            busy_eff_s;
    logic [31:0]            wb_mask_s;
    logic [31:0]            set_mask_s;
    logic [STALL_CNT_W-1:0] stall_cnt_r;
    logic                   uses_rs1_s;
    logic                   uses_rs2_s;
    logic                   is_load_s;
    logic                   hazard_s;
    logic                   hold_s;
    logic                   ex_valid_s;
    logic                   issue_s;
    logic                   fetch_ready_s;
    logic                   accept_s;
    logic                   stall_inc_s;

    // Operand usage, hazard check against the scoreboard, and handshake terms
    always_comb begin
        uses_rs1_s = dec_r_type_i | dec_i_type_i | dec_s_type_i | dec_b_type_i;
        uses_rs2_s = dec_r_type_i | dec_s_type_i | dec_b_type_i;
        is_load_s  = (dec_op_i == OP_LOAD);
        wb_mask_s  = wb_valid_i ? (32'd1 << wb_rd_i) : 32'd0;
`ifdef DECODE_ISSUE_WB_BYPASS_EN
        busy_eff_s = busy_r & ~wb_mask_s;
`else
        busy_eff_s = busy_r;
`endif
        busy_eff_s[0] = 1'b0;
        hazard_s      = (uses_rs1_s & busy_eff_s[dec_rs1_i]) |
                        (uses_rs2_s & busy_eff_s[dec_rs2_i]);
        hold_s        = (state_r == ST_HOLD);
        ex_valid_s    = hold_s & ~hazard_s & ~flush_i;
        issue_s       = ex_valid_s & ex_ready_i;
        // Ready depends on ex_ready_i so a full stage can refill in the cycle it drains
        fetch_ready_s = ~rst_i & ~flush_i & (~hold_s | issue_s);
        accept_s      = fetch_valid_i & fetch_ready_s;
        stall_inc_s   = hold_s & hazard_s & ~flush_i;
    end

    // Next-state selection; flush empties the stage regardless of handshakes
    always_comb begin
        state_nxt_s = state_r;
        if (flush_i) begin
            state_nxt_s = ST_EMPTY;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (accept_s) begin
                        state_nxt_s = ST_HOLD;
                    end else begin
                        state_nxt_s = ST_EMPTY;
                    end
                end
                ST_HOLD: begin
                    if (issue_s & ~accept_s) begin
                        state_nxt_s = ST_EMPTY;
                    end else begin
                        state_nxt_s = ST_HOLD;
                    end
                end
                default: state_nxt_s = ST_EMPTY;
            endcase
        end
    end

    // Scoreboard next value: write-back clears, issued load sets, set wins on collision
    always_comb begin
        set_mask_s    = (issue_s & is_load_s & (dec_rd_i != 5'd0)) ? (32'd1 << dec_rd_i) : 32'd0;
        busy_nxt_s    = (busy_r & ~wb_mask_s) | set_mask_s;
        busy_nxt_s[0] = 1'b0;
    end

    // State, scoreboard and stage register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= ST_EMPTY;
            busy_r  <= 32'd0;
            instr_r <= NOP_INSTR;
            pc_r    <= {XLEN{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= busy_nxt_s;
            if (flush_i) begin
                instr_r <= NOP_INSTR;
            end else if (accept_s) begin
                instr_r <= fetch_instr_i;
                pc_r    <= fetch_pc_i;
            end
        end
    end

    // Saturating count of hazard-blocked cycles
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_r <= {STALL_CNT_W{1'b0}};
        end else if (stall_inc_s && (stall_cnt_r != {STALL_CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + STALL_CNT_W'(1);
        end
    end

    assign fetch_ready_o = fetch_ready_s;
    assign ex_valid_o    = ex_valid_s;
    assign dec_instr_o   = instr_r;
    assign ex_instr_o    = instr_r;
    assign ex_pc_o       = pc_r;
    assign stall_cnt_o   = stall_cnt_r;

endmodule
